// File: rtl/cache_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// cache_axi_rd_arbiter
//   Round-robin arbiter that funnels NREQ cache read requestors onto a single
//   AXI read channel. One transaction in flight at a time:
//   IDLE -> AR -> R -> DONE -> IDLE.
//   Cached requests issue an INCR line-fill burst of LINE_WORDS beats to a
//   line-aligned address. Uncached requests issue a single beat to the
//   unmodified address. Returned data is assembled into a registered line
//   buffer. A flush marks the in-flight result as discarded. The bus
//   transaction still runs to completion, but no done pulse is given.
//
// Ports
//   clk, resetn      clock (rising edge), async active-low reset
//   flush            discard the result of the in-flight request
//   req_i            per-requestor read request, held until done_o
//   req_addr_i       per-requestor address, slice k = requestor k
//   req_uncached_i   1 = single-word access, 0 = line fill
//   done_o           one-cycle completion pulse to the granted requestor
//   err_o            one-cycle error pulse with done_o (any rresp != OKAY)
//   line_o           assembled line, word i at bits [32i+31:32i]
//   ar*/r*           AXI read address / read data channels (master side)
// ---------------------------------------------------------------------------
module cache_axi_rd_arbiter #(
    parameter int NREQ       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*32-1:0]      req_addr_i,
    input  logic [NREQ-1:0]         req_uncached_i,
    output logic [NREQ-1:0]         done_o,
    output logic                    err_o,
    output logic [LINE_WORDS*32-1:0] line_o,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF = $clog2(LINE_WORDS * 4);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF) - 32'd1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_e;

    state_e                         state_q, state_d;
    logic [GW-1:0]                  grant_q, grant_d;
    logic [GW-1:0]                  last_grant_q, last_grant_d;
    logic                           unc_q, unc_d;
    logic                           discard_q, discard_d;
    logic                           err_q, err_d;
    logic [BW-1:0]                  beat_q, beat_d;
    logic [31:0]                    araddr_q, araddr_d;
    logic [7:0]                     arlen_q, arlen_d;
    logic [3:0]                     arid_q, arid_d;
    logic [LINE_WORDS-1:0][31:0]    line_q, line_d;

    logic [NREQ-1:0][31:0]          addr_arr;
    logic [GW-1:0]                  gnt_idx;
    logic                           gnt_found;
    logic [BW-1:0]                  widx;
    int                             cand;

    // rid is deliberately ignored: only one transaction is ever outstanding.
    logic unused_rid;
    assign unused_rid = ^rid;

    assign addr_arr = req_addr_i;

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(last_grant_q) + 1 + i) % NREQ;
            if (!gnt_found && req_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = GW'(cand);
            end
        end
    end

    // Uncached accesses always land in word 0 regardless of the beat count.
    assign widx = unc_q ? '0 : beat_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unc_d        = unc_q;
        discard_d    = discard_q;
        err_d        = err_q;
        beat_d       = beat_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arid_d       = arid_q;
        line_d       = line_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    grant_d   = gnt_idx;
                    unc_d     = req_uncached_i[gnt_idx];
                    araddr_d  = req_uncached_i[gnt_idx] ? addr_arr[gnt_idx]
                                                        : (addr_arr[gnt_idx] & LINE_MASK);
                    arlen_d   = req_uncached_i[gnt_idx] ? 8'd0 : 8'(LINE_WORDS - 1);
                    arid_d    = 4'(gnt_idx);
                    discard_d = 1'b0;
                    err_d     = 1'b0;
                    beat_d    = '0;
                    state_d   = S_AR;
                end
            end
            S_AR: begin
                // AR is never withdrawn; flush only marks the result as dead.
                if (flush)   discard_d = 1'b1;
                if (arready) state_d   = S_R;
            end
            S_R: begin
                if (flush) discard_d = 1'b1;
                if (rvalid) begin
                    line_d[widx] = rdata;
                    beat_d       = (beat_q == BW'(LINE_WORDS - 1)) ? '0 : beat_q + 1'b1;
                    if (rresp != 2'b00) err_d = 1'b1;
                    if (rlast)          state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush) discard_d = 1'b1;
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            unc_q        <= 1'b0;
            discard_q    <= 1'b0;
            err_q        <= 1'b0;
            beat_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arid_q       <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            unc_q        <= unc_d;
            discard_q    <= discard_d;
            err_q        <= err_d;
            beat_q       <= beat_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arid_q       <= arid_d;
            line_q       <= line_d;
        end
    end

    always_comb begin
        done_o = '0;
        if (state_q == S_DONE && !discard_q) done_o[grant_q] = 1'b1;
    end

    assign err_o   = (state_q == S_DONE) && !discard_q && err_q;
    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_R);
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arid    = arid_q;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign line_o  = line_q;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
module tb_cache_axi_rd_arbiter;

    localparam int NREQ = 2;
    localparam int LW   = 4;

    logic               clk;
    logic               resetn;
    logic               flush;
    logic [NREQ-1:0]    req_i;
    logic [NREQ*32-1:0] req_addr_i;
    logic [NREQ-1:0]    req_uncached_i;
    logic [NREQ-1:0]    done_o;
    logic               err_o;
    logic [LW*32-1:0]   line_o;
    logic [3:0]         arid;
    logic [31:0]        araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arvalid;
    logic               arready;
    logic [3:0]         rid;
    logic [31:0]        rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready;

    int vecs = 0;
    int errs = 0;

    cache_axi_rd_arbiter #(.NREQ(NREQ), .LINE_WORDS(LW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req_i(req_i), .req_addr_i(req_addr_i), .req_uncached_i(req_uncached_i),
        .done_o(done_o), .err_o(err_o), .line_o(line_o),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---- stimulus helpers (no checking) ----
    task automatic do_reset();
        resetn = 1'b0; flush = 1'b0; req_i = '0; req_uncached_i = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0; rdata = '0;
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the first negedge with arvalid high (bounded).
    task automatic wait_ar(output bit ok, output bit saw_done);
        ok = 1'b0; saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o != '0) saw_done = 1'b1;
            if (arvalid) begin ok = 1'b1; break; end
        end
    endtask

    // Accepts AR, then returns n beats; returns at the negedge of the DONE cycle.
    task automatic serve_beats(input int n, input logic [3:0][31:0] dat,
                               input int err_beat, input int flush_beat, output bit rdy_ok);
        rdy_ok = 1'b1;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int k = 0; k < n; k++) begin
            rvalid = 1'b1;
            rdata  = dat[k];
            rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            rlast  = (k == n - 1);
            flush  = (k == flush_beat);
            rid    = 4'hF;
            if (!rready) rdy_ok = 1'b0;
            @(negedge clk);
            flush = 1'b0;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; req_i = '0; req_uncached_i = '0; req_addr_i = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0; rdata = '0; rid = '0;
        @(negedge clk); @(negedge clk);
        vecs++; if (arvalid !== 1'b0) begin errs++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
        vecs++; if (rready !== 1'b0) begin errs++; $display("FAIL rst_rready got=%b exp=0", rready); end
        vecs++; if (done_o !== 2'b00 || err_o !== 1'b0) begin errs++; $display("FAIL rst_done got=%b/%b exp=00/0", done_o, err_o); end
        vecs++; if (line_o !== '0) begin errs++; $display("FAIL rst_line got=%h exp=0", line_o); end
        vecs++; if (araddr !== 32'h0 || arid !== 4'h0 || arlen !== 8'h0) begin errs++;
            $display("FAIL rst_ar got=%h/%h/%h exp=0/0/0", araddr, arid, arlen); end
        resetn = 1'b1;
        @(negedge clk); @(negedge clk);
        vecs++; if (arvalid !== 1'b0) begin errs++; $display("FAIL idle_arvalid got=%b exp=0", arvalid); end
    endtask

    task automatic test_cached_fill();
        bit ok, sd, rok;
        req_addr_i = {32'h0, 32'h1FC0_0014};
        req_uncached_i = 2'b00;
        req_i = 2'b01;
        wait_ar(ok, sd);
        vecs++; if (!ok) begin errs++; $display("FAIL cf_ar_timeout got=0 exp=1"); end
        vecs++; if (araddr !== 32'h1FC0_0010) begin errs++; $display("FAIL cf_araddr got=%h exp=1fc00010", araddr); end
        vecs++; if (arlen !== 8'd3 || arid !== 4'd0) begin errs++; $display("FAIL cf_arlen_id got=%0d/%0d exp=3/0", arlen, arid); end
        vecs++; if (arsize !== 3'b010 || arburst !== 2'b01) begin errs++; $display("FAIL cf_size_burst got=%b/%b exp=010/01", arsize, arburst); end
        serve_beats(4, {32'd4, 32'd3, 32'd2, 32'd1}, -1, -1, rok);
        req_i = 2'b00;
        vecs++; if (done_o !== 2'b01 || err_o !== 1'b0) begin errs++; $display("FAIL cf_done got=%b/%b exp=01/0", done_o, err_o); end
        vecs++; if (line_o !== {32'd4, 32'd3, 32'd2, 32'd1}) begin errs++; $display("FAIL cf_line got=%h exp=4_3_2_1", line_o); end
        @(negedge clk);
        vecs++; if (done_o !== 2'b00) begin errs++; $display("FAIL cf_done_pulse got=%b exp=00", done_o); end
    endtask

    task automatic test_uncached();
        bit ok, sd, rok;
        req_addr_i = {32'hBFAF_8004, 32'h0};
        req_uncached_i = 2'b10;
        req_i = 2'b10;
        wait_ar(ok, sd);
        vecs++; if (!ok) begin errs++; $display("FAIL uc_ar_timeout got=0 exp=1"); end
        vecs++; if (araddr !== 32'hBFAF_8004) begin errs++; $display("FAIL uc_araddr got=%h exp=bfaf8004", araddr); end
        vecs++; if (arlen !== 8'd0 || arid !== 4'd1) begin errs++; $display("FAIL uc_arlen_id got=%0d/%0d exp=0/1", arlen, arid); end
        serve_beats(1, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, -1, -1, rok);
        req_i = 2'b00;
        vecs++; if (done_o !== 2'b10) begin errs++; $display("FAIL uc_done got=%b exp=10", done_o); end
        vecs++; if (line_o !== {32'd4, 32'd3, 32'd2, 32'hDEAD_BEEF}) begin errs++;
            $display("FAIL uc_line got=%h exp=4_3_2_deadbeef", line_o); end
        req_uncached_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_contention();
        bit ok, sd, rok;
        int exp;
        do_reset();
        req_addr_i = {32'h0000_2040, 32'h0000_1000};
        req_uncached_i = 2'b00;
        req_i = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp = t % 2;
            wait_ar(ok, sd);
            vecs++; if (!ok) begin errs++; $display("FAIL ct_ar_timeout t=%0d got=0 exp=1", t); end
            vecs++; if (arid !== 4'(exp)) begin errs++; $display("FAIL ct_arid t=%0d got=%0d exp=%0d", t, arid, exp); end
            serve_beats(4, {32'(t), 32'(t), 32'(t), 32'(t)}, -1, -1, rok);
            if (t == 3) req_i = 2'b00;
            vecs++; if (done_o !== (2'b01 << exp)) begin errs++; $display("FAIL ct_done t=%0d got=%b exp=%b", t, done_o, 2'b01 << exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_flush_r();
        bit ok, sd, rok;
        req_addr_i = {32'h0, 32'h0000_0100};
        req_i = 2'b01;
        wait_ar(ok, sd);
        vecs++; if (!ok) begin errs++; $display("FAIL fl_ar_timeout got=0 exp=1"); end
        serve_beats(4, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, -1, 1, rok);
        req_i = 2'b00;
        vecs++; if (!rok) begin errs++; $display("FAIL fl_rready got=0 exp=1"); end
        vecs++; if (done_o !== 2'b00 || err_o !== 1'b0) begin errs++; $display("FAIL fl_done got=%b/%b exp=00/0", done_o, err_o); end
        @(negedge clk);
        req_i = 2'b01;
        wait_ar(ok, sd);
        vecs++; if (!ok) begin errs++; $display("FAIL fl2_ar_timeout got=0 exp=1"); end
        serve_beats(4, {32'hB4, 32'hB3, 32'hB2, 32'hB1}, -1, -1, rok);
        req_i = 2'b00;
        vecs++; if (done_o !== 2'b01) begin errs++; $display("FAIL fl2_done got=%b exp=01", done_o); end
        vecs++; if (line_o !== {32'hB4, 32'hB3, 32'hB2, 32'hB1}) begin errs++; $display("FAIL fl2_line got=%h exp=b4_b3_b2_b1", line_o); end
        @(negedge clk);
    endtask

    task automatic test_ar_stall_err();
        bit ok, sd, rok, stable;
        req_addr_i = {32'h0, 32'h0000_1238};
        req_i = 2'b01;
        wait_ar(ok, sd);
        vecs++; if (!ok) begin errs++; $display("FAIL st_ar_timeout got=0 exp=1"); end
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (arvalid !== 1'b1 || araddr !== 32'h0000_1230) stable = 1'b0;
            flush = (c == 2);
            @(negedge clk);
        end
        flush = 1'b0;
        vecs++; if (!stable) begin errs++; $display("FAIL st_ar_stable got=0 exp=1"); end
        vecs++; if (arvalid !== 1'b1) begin errs++; $display("FAIL st_ar_held got=%b exp=1", arvalid); end
        serve_beats(4, {32'h4, 32'h3, 32'h2, 32'h1}, -1, -1, rok);
        req_i = 2'b00;
        vecs++; if (done_o !== 2'b00) begin errs++; $display("FAIL st_discard got=%b exp=00", done_o); end
        @(negedge clk);
        req_addr_i = {32'h0, 32'h0000_0040};
        req_i = 2'b01;
        wait_ar(ok, sd);
        serve_beats(4, {32'h14, 32'h13, 32'h12, 32'h11}, 1, -1, rok);
        req_i = 2'b00;
        vecs++; if (done_o !== 2'b01 || err_o !== 1'b1) begin errs++; $display("FAIL st_err got=%b/%b exp=01/1", done_o, err_o); end
        @(negedge clk);
        vecs++; if (err_o !== 1'b0) begin errs++; $display("FAIL st_err_pulse got=%b exp=0", err_o); end
        req_i = 2'b01;
        wait_ar(ok, sd);
        serve_beats(4, {32'h24, 32'h23, 32'h22, 32'h21}, -1, -1, rok);
        req_i = 2'b00;
        vecs++; if (done_o !== 2'b01 || err_o !== 1'b0) begin errs++; $display("FAIL st_err_clr got=%b/%b exp=01/0", done_o, err_o); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        bit ok, sd, rok;
        req_addr_i = {32'h0000_2000, 32'h0};
        req_i = 2'b10;
        wait_ar(ok, sd);
        vecs++; if (!ok) begin errs++; $display("FAIL rm_ar_timeout got=0 exp=1"); end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hC1; rlast = 1'b0;
        @(negedge clk);
        rdata = 32'hC2;
        @(negedge clk);
        rdata = 32'hC3;
        #1 resetn = 1'b0;
        #1;
        vecs++; if (arvalid !== 1'b0 || rready !== 1'b0) begin errs++; $display("FAIL rm_handshake got=%b/%b exp=0/0", arvalid, rready); end
        vecs++; if (done_o !== 2'b00 || err_o !== 1'b0) begin errs++; $display("FAIL rm_done got=%b/%b exp=00/0", done_o, err_o); end
        vecs++; if (line_o !== '0) begin errs++; $display("FAIL rm_line got=%h exp=0", line_o); end
        vecs++; if (araddr !== 32'h0 || arid !== 4'h0 || arlen !== 8'h0) begin errs++;
            $display("FAIL rm_ar got=%h/%h/%h exp=0/0/0", araddr, arid, arlen); end
        rvalid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        wait_ar(ok, sd);
        vecs++; if (!ok || sd) begin errs++; $display("FAIL rm_fresh_ar got=ok%b/done%b exp=ok1/done0", ok, sd); end
        vecs++; if (arid !== 4'd1 || araddr !== 32'h0000_2000 || arlen !== 8'd3) begin errs++;
            $display("FAIL rm_ar_args got=%h/%h/%h exp=1/2000/3", arid, araddr, arlen); end
        serve_beats(4, {32'hD4, 32'hD3, 32'hD2, 32'hD1}, -1, -1, rok);
        req_i = 2'b00;
        vecs++; if (done_o !== 2'b10) begin errs++; $display("FAIL rm_done2 got=%b exp=10", done_o); end
        vecs++; if (line_o !== {32'hD4, 32'hD3, 32'hD2, 32'hD1}) begin errs++; $display("FAIL rm_line2 got=%h exp=d4_d3_d2_d1", line_o); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cached_fill();
        test_uncached();
        test_contention();
        test_flush_r();
        test_ar_stall_err();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Absolute time bound so a wedged DUT still reaches a verdict.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_axi_rd_arbiter.md
CACHE_AXI_RD_ARBITER -- requirements
Module: cache_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of read requestors (icache, dcache, ...); legal 1..8.
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per cache line; power of 2, 1..16.
REQ-003 SHALL have ports (clk first, then reset), one per line:
 clk  in  1  sole clock, rising edge;
 resetn  in  1  asynchronous active-low reset;
 flush  in  1  pipeline flush, discards result of in-flight request;
 req_i  in  NREQ  per-requestor read request, held until done_o;
 req_addr_i  in  NREQ*32  per-requestor address, slice k = requestor k;
 req_uncached_i  in  NREQ  1 = single-word access, 0 = line fill;
 done_o  out  NREQ  one-cycle completion pulse to granted requestor;
 err_o  out  1  one-cycle pulse with done_o if any beat had rresp!=0;
 line_o  out  LINE_WORDS*32  assembled line, word i at bits [32i+31:32i];
 arid  out  4;  araddr  out  32;  arlen  out  8;  arsize  out  3;  arburst  out  2;
 arvalid  out  1;  arready  in  1;
 rid  in  4;  rdata  in  32;  rresp  in  2;  rlast  in  1;  rvalid  in  1;  rready  out  1.

Function
REQ-004 SHALL implement FSM IDLE -> AR -> R -> DONE -> IDLE, one request in flight.
REQ-005 IDLE: if any req_i bit set, SHALL grant by round-robin, search starting at (last_grant+1) mod NREQ; latch index, address, uncached flag; go AR next edge.
REQ-006 AR: arvalid=1, arid=grant index, arsize=3'b010; cached: arlen=LINE_WORDS-1, arburst=2'b01, araddr low log2(LINE_WORDS*4) bits zeroed; uncached: arlen=0, arburst=2'b01, araddr unmodified.
REQ-007 AR args SHALL be stable while arvalid=1; arvalid SHALL NOT drop before arready (flush does not cancel AR).
REQ-008 AR with arready=1 SHALL go R next edge; arvalid=0 in all other states.
REQ-009 R: rready=1; each rvalid&rready SHALL write rdata into word[beat] of line buffer and increment beat (mod LINE_WORDS); uncached writes word 0 only, other words keep previous values.
REQ-010 R: rvalid&rready&rlast SHALL go DONE; burst end determined by rlast only; rid not checked.
REQ-011 Any accepted beat with rresp!=2'b00 SHALL set sticky error flag, cleared on entering AR.
REQ-012 DONE: done_o[grant]=1 and err_o=error flag for exactly one cycle unless discard flag set (then done_o=0, err_o=0); last_grant <= grant; go IDLE.
REQ-013 flush=1 in AR, R or DONE SHALL set discard flag; flag cleared on entering AR from IDLE; flush in IDLE has no effect.
REQ-014 line_o SHALL be the registered buffer, valid from done_o cycle until next beat written.
REQ-015 Latency: req_i seen in IDLE at edge t -> arvalid high after t; last beat accepted at edge u -> done_o high during cycle after u; minimum 4 cycles req to done with zero-wait slave and single beat.
REQ-016 Requestors SHALL drop req_i the cycle after done_o; a new request arriving during AR/R/DONE waits in IDLE arbitration.
REQ-017 Single requesting channel SHALL be granted back-to-back regardless of pointer.

Reset
REQ-018 resetn=0 SHALL asynchronously force state IDLE, arvalid=0, rready=0, done_o=0, err_o=0, line_o=0, araddr/arid/arlen=0, last_grant=NREQ-1, discard and error flags 0.
REQ-019 Reset mid-burst SHALL abandon the transaction; no done_o after release.

Verification
REQ-020 Cached fill: req_i=2'b01, addr 0x1FC0_0014, slave returns 1,2,3,4 -> araddr=0x1FC0_0010, arlen=3, arid=0, line_o={4,3,2,1}, done_o=2'b01 one cycle.
REQ-021 Contention: req_i=2'b11 held, after reset -> grant order 0,1,0,1; arid matches; each done_o one-hot.
REQ-022 Uncached: req_uncached_i[1]=1, addr 0xBFAF_8004 -> araddr=0xBFAF_8004, arlen=0, word 0 = rdata, done_o=2'b10.
REQ-023 Flush during R (beat 2 of 4) -> burst completes with rready=1, done_o stays 0, next request served normally.
REQ-024 arready held low 5 cycles with flush pulse -> arvalid and araddr stable all 5 cycles; rresp=2'b10 on beat 1 of later unflushed fill -> err_o=1 with done_o.
REQ-025 resetn low during R beat 2 -> outputs at reset values immediately; after release, new request issues fresh AR.
